// File: rtl/word_ram_rr_arbiter_pkg.sv
// Shared types and constants for the word-wide RAM round-robin arbiter.
// State encoding, bus widths and the grant-index width helper.
package wrrarb_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2,
    DONE   = 2'd3
  } state_e;

  // A single core still needs a 1-bit index.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/word_ram_rr_arbiter_if.sv
// Core-array and RAM-side bus of the word RAM arbiter.
// slave is the arbiter's view, master the view of the cores plus RAM.
interface word_ram_rr_arbiter_if #(
  parameter int unsigned NumberOfCores = 4
);
  import wrrarb_pkg::*;

  logic [NumberOfCores-1:0]        REQ_WR;
  logic [NumberOfCores-1:0]        REQ_RR;
  logic [ADDR_W*NumberOfCores-1:0] REQ_ADDR;
  logic [DATA_W*NumberOfCores-1:0] REQ_WDATA;
  logic [NumberOfCores-1:0]        ACK;
  logic [DATA_W-1:0]               RDATA;
  logic                            RAM_WE;
  logic [ADDR_W-1:0]               RAM_ADDR;
  logic [DATA_W-1:0]               RAM_WDATA;
  logic [DATA_W-1:0]               RAM_RDATA;

  modport slave (
    input  REQ_WR, REQ_RR, REQ_ADDR, REQ_WDATA, RAM_RDATA,
    output ACK, RDATA, RAM_WE, RAM_ADDR, RAM_WDATA
  );

  modport master (
    output REQ_WR, REQ_RR, REQ_ADDR, REQ_WDATA, RAM_RDATA,
    input  ACK, RDATA, RAM_WE, RAM_ADDR, RAM_WDATA
  );

endinterface

// File: rtl/word_ram_rr_arbiter_picker.sv
// Combinational round-robin pick: rotate the request vector by the pointer,
// find the first set bit, then map the offset back to a core index.
module rr_priority_picker import wrrarb_pkg::*; #(
  parameter int unsigned NumberOfCores = 4,
  parameter int unsigned IdxW          = idx_width(NumberOfCores)
) (
  input  logic [NumberOfCores-1:0] req_i,
  input  logic [IdxW-1:0]          ptr_i,
  output logic                     found_o,
  output logic [IdxW-1:0]          idx_o
);

  localparam logic [IdxW:0] NCores = (IdxW+1)'(NumberOfCores);

  logic [2*NumberOfCores-1:0] req_dbl;
  logic [NumberOfCores-1:0]   rot;
  logic [IdxW-1:0]            off;
  logic [IdxW:0]              sum;

  assign req_dbl = {req_i, req_i};
  assign rot     = req_dbl[ptr_i +: NumberOfCores];

  always_comb begin
    found_o = 1'b0;
    off     = '0;
    for (int unsigned i = 0; i < NumberOfCores; i++) begin
      if (!found_o && rot[i]) begin
        found_o = 1'b1;
        off     = IdxW'(i);
      end
    end
    // Wrap explicitly so non-power-of-2 core counts never yield an index >= NumberOfCores.
    sum = {1'b0, ptr_i} + {1'b0, off};
    if (sum >= NCores) begin
      sum = sum - NCores;
    end
    idx_o = sum[IdxW-1:0];
  end

endmodule

// File: rtl/word_ram_rr_arbiter.sv
// Round-robin arbiter sharing one 8-bit/16-bit-address RAM port between cores.
// Each access runs IDLE -> ACCESS -> [RDWAIT] -> DONE; every output is registered.
module word_ram_rr_arbiter import wrrarb_pkg::*; #(
  parameter int unsigned  NumberOfCores = 4,
  parameter int unsigned  ReadLatency   = 1,
  localparam int unsigned IdxW          = idx_width(NumberOfCores)
) (
  input  logic                 CLK,
  input  logic                 WRRARB_RESET,
  input  logic                 WRRARB_HOLD,
  word_ram_rr_arbiter_if.slave bus,
  output logic                 BUSY,
  output logic [IdxW-1:0]      GRANT_IDX
);

  localparam logic [2:0]      CntInit = 3'(ReadLatency - 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumberOfCores - 1);

  state_e                   state_q, state_d;
  logic [IdxW-1:0]          ptr_q, ptr_d;
  logic [IdxW-1:0]          grant_q, grant_d;
  logic                     op_wr_q, op_wr_d;
  logic [2:0]               cnt_q, cnt_d;
  logic [NumberOfCores-1:0] ack_q, ack_d;
  logic [DATA_W-1:0]        rdata_q, rdata_d;
  logic                     ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]        ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]        ram_wdata_q, ram_wdata_d;
  logic                     busy_q, busy_d;

  logic [NumberOfCores-1:0] req;
  logic                     found;
  logic [IdxW-1:0]          pick;

  assign req = bus.REQ_WR | bus.REQ_RR;

  rr_priority_picker #(
    .NumberOfCores (NumberOfCores),
    .IdxW          (IdxW)
  ) u_picker (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .found_o (found),
    .idx_o   (pick)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    op_wr_d     = op_wr_q;
    cnt_d       = cnt_q;
    ack_d       = '0;
    rdata_d     = rdata_q;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = '0;
    busy_d      = busy_q;

    unique case (state_q)
      IDLE: begin
        if (!WRRARB_HOLD && found) begin
          // Write wins when a core raises both WR and RR.
          grant_d    = pick;
          op_wr_d    = bus.REQ_WR[pick];
          ram_addr_d = bus.REQ_ADDR[ADDR_W*pick +: ADDR_W];
          ram_we_d   = bus.REQ_WR[pick];
          if (bus.REQ_WR[pick]) begin
            ram_wdata_d = bus.REQ_WDATA[DATA_W*pick +: DATA_W];
          end
          busy_d  = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (op_wr_q) begin
          ack_d[grant_q] = 1'b1;
          state_d        = DONE;
        end else begin
          cnt_d   = CntInit;
          state_d = RDWAIT;
        end
      end
      RDWAIT: begin
        if (cnt_q == 3'd0) begin
          rdata_d        = bus.RAM_RDATA;
          ack_d[grant_q] = 1'b1;
          state_d        = DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      DONE: begin
        ptr_d   = (grant_q == LastIdx) ? '0 : grant_q + 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge WRRARB_RESET) begin
    if (WRRARB_RESET) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      op_wr_q     <= 1'b0;
      cnt_q       <= '0;
      ack_q       <= '0;
      rdata_q     <= '0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      op_wr_q     <= op_wr_d;
      cnt_q       <= cnt_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.ACK       = ack_q;
  assign bus.RDATA     = rdata_q;
  assign bus.RAM_WE    = ram_we_q;
  assign bus.RAM_ADDR  = ram_addr_q;
  assign bus.RAM_WDATA = ram_wdata_q;
  assign BUSY          = busy_q;
  assign GRANT_IDX     = grant_q;

endmodule

// File: tb/tb_word_ram_rr_arbiter.sv
// Directed bench for word_ram_rr_arbiter: 4 cores, ReadLatency = 3.
// A pipelined RAM model returns 0x5C at 0x00FF and addr[7:0]^0x3C elsewhere.
module tb_word_ram_rr_arbiter;

  logic       CLK = 1'b0;
  logic       rst;
  logic       hold;
  logic       busy;
  logic [1:0] grant_idx;
  int         n_vec = 0;
  int         n_bad = 0;

  word_ram_rr_arbiter_if #(.NumberOfCores(4)) bus ();

  word_ram_rr_arbiter #(
    .NumberOfCores (4),
    .ReadLatency   (3)
  ) dut (
    .CLK          (CLK),
    .WRRARB_RESET (rst),
    .WRRARB_HOLD  (hold),
    .bus          (bus),
    .BUSY         (busy),
    .GRANT_IDX    (grant_idx)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] ram_mem(input logic [15:0] a);
    return (a == 16'h00FF) ? 8'h5C : (a[7:0] ^ 8'h3C);
  endfunction

  // Three-stage read pipe: data for the address presented at edge N is visible after edge N+3.
  logic [7:0] rd_pipe [3];
  always @(posedge CLK) begin
    rd_pipe[0] <= ram_mem(bus.RAM_ADDR);
    rd_pipe[1] <= rd_pipe[0];
    rd_pipe[2] <= rd_pipe[1];
  end
  assign bus.RAM_RDATA = rd_pipe[2];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $fatal(1, "FAIL timeout: bench did not reach its summary");
  end

  initial begin
    int waited;
    rst           = 1'b1;
    hold          = 1'b0;
    bus.REQ_WR    = '0;
    bus.REQ_RR    = '0;
    bus.REQ_ADDR  = '0;
    bus.REQ_WDATA = '0;

    // Reset state
    tick();
    tick();
    check("rst_ack", 32'(bus.ACK), 32'h0);
    check("rst_rdata", 32'(bus.RDATA), 32'h0);
    check("rst_we", 32'(bus.RAM_WE), 32'h0);
    check("rst_addr", 32'(bus.RAM_ADDR), 32'h0);
    check("rst_wdata", 32'(bus.RAM_WDATA), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_grant", 32'(grant_idx), 32'h0);
    rst = 1'b0;
    tick();

    // Single write from core 1; cycle 1 is the IDLE cycle that samples the request
    bus.REQ_WR[1]         = 1'b1;
    bus.REQ_ADDR[16 +: 16] = 16'h1234;
    bus.REQ_WDATA[8 +: 8]  = 8'hA5;
    check("wr_c1_ack", 32'(bus.ACK), 32'h0);
    tick();
    check("wr_c2_we", 32'(bus.RAM_WE), 32'h1);
    check("wr_c2_addr", 32'(bus.RAM_ADDR), 32'h1234);
    check("wr_c2_wdata", 32'(bus.RAM_WDATA), 32'hA5);
    check("wr_c2_busy", 32'(busy), 32'h1);
    check("wr_c2_grant", 32'(grant_idx), 32'h1);
    check("wr_c2_ack", 32'(bus.ACK), 32'h0);
    tick();
    check("wr_c3_ack", 32'(bus.ACK), 32'h2);
    check("wr_c3_we", 32'(bus.RAM_WE), 32'h0);
    bus.REQ_WR[1] = 1'b0;
    tick();
    check("wr_c4_ack", 32'(bus.ACK), 32'h0);
    check("wr_c4_busy", 32'(busy), 32'h0);

    // Write from core 2 moves the pointer to 3
    bus.REQ_WR[2]          = 1'b1;
    bus.REQ_ADDR[32 +: 16] = 16'h2000;
    bus.REQ_WDATA[16 +: 8] = 8'h11;
    tick();
    tick();
    check("wr2_ack", 32'(bus.ACK), 32'h4);
    bus.REQ_WR[2] = 1'b0;
    tick();

    // Read from core 3 abandoned by reset while in RDWAIT
    bus.REQ_RR[3]          = 1'b1;
    bus.REQ_ADDR[48 +: 16] = 16'h0042;
    tick();
    check("rdrst_grant", 32'(grant_idx), 32'h3);
    check("rdrst_we", 32'(bus.RAM_WE), 32'h0);
    tick();
    check("rdrst_busy_pre", 32'(busy), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("rdrst_ack", 32'(bus.ACK), 32'h0);
    check("rdrst_busy", 32'(busy), 32'h0);
    check("rdrst_addr", 32'(bus.RAM_ADDR), 32'h0);
    check("rdrst_grant0", 32'(grant_idx), 32'h0);
    check("rdrst_rdata", 32'(bus.RDATA), 32'h0);
    bus.REQ_RR[3] = 1'b0;
    tick();
    check("rdrst_ack_held", 32'(bus.ACK), 32'h0);
    rst = 1'b0;
    tick();

    // Cores 2 and 3 together: pointer is back at 0, so core 2 goes first
    bus.REQ_WR[2]          = 1'b1;
    bus.REQ_ADDR[32 +: 16] = 16'h2222;
    bus.REQ_WDATA[16 +: 8] = 8'h22;
    bus.REQ_WR[3]          = 1'b1;
    bus.REQ_ADDR[48 +: 16] = 16'h3333;
    bus.REQ_WDATA[24 +: 8] = 8'h33;
    tick();
    check("post_rst_grant", 32'(grant_idx), 32'h2);
    check("post_rst_addr", 32'(bus.RAM_ADDR), 32'h2222);
    tick();
    check("post_rst_ack2", 32'(bus.ACK), 32'h4);
    bus.REQ_WR[2] = 1'b0;
    tick();
    tick();
    check("post_rst_grant3", 32'(grant_idx), 32'h3);
    tick();
    check("post_rst_ack3", 32'(bus.ACK), 32'h8);
    bus.REQ_WR[3] = 1'b0;
    tick();

    // Read from core 0 at 0x00FF: ACK and RDATA in cycle 6
    bus.REQ_RR[0]         = 1'b1;
    bus.REQ_ADDR[0 +: 16] = 16'h00FF;
    check("rd_c1_ack", 32'(bus.ACK), 32'h0);
    for (int c = 2; c <= 5; c++) begin
      tick();
      check("rd_early_ack", 32'(bus.ACK), 32'h0);
    end
    check("rd_c5_rdata", 32'(bus.RDATA), 32'h0);
    tick();
    check("rd_c6_ack", 32'(bus.ACK), 32'h1);
    check("rd_c6_rdata", 32'(bus.RDATA), 32'h5C);
    bus.REQ_RR[0] = 1'b0;
    tick();

    // WR and RR together on core 3: one write, no read capture
    bus.REQ_WR[3]          = 1'b1;
    bus.REQ_RR[3]          = 1'b1;
    bus.REQ_ADDR[48 +: 16] = 16'h0077;
    bus.REQ_WDATA[24 +: 8] = 8'h77;
    tick();
    check("wrrr_we", 32'(bus.RAM_WE), 32'h1);
    check("wrrr_wdata", 32'(bus.RAM_WDATA), 32'h77);
    check("wrrr_grant", 32'(grant_idx), 32'h3);
    tick();
    check("wrrr_ack", 32'(bus.ACK), 32'h8);
    check("wrrr_rdata", 32'(bus.RDATA), 32'h5C);
    bus.REQ_WR[3] = 1'b0;
    bus.REQ_RR[3] = 1'b0;
    tick();
    check("wrrr_idle", 32'(busy), 32'h0);

    // Fairness: all four cores write continuously, pointer starts at 0
    for (int k = 0; k < 4; k++) begin
      bus.REQ_ADDR[16*k +: 16] = 16'h4000 | 16'(k);
      bus.REQ_WDATA[8*k +: 8]  = 8'(k);
    end
    bus.REQ_WR = 4'hF;
    for (int g = 0; g < 6; g++) begin
      waited = 0;
      tick();
      while (bus.ACK == 4'h0 && waited < 8) begin
        tick();
        waited++;
      end
      check("fair_ack", 32'(bus.ACK), 32'(1) << (g % 4));
    end
    bus.REQ_WR = 4'h0;
    tick();

    // Hold: no grant while high, an access already started still completes
    hold                  = 1'b1;
    bus.REQ_WR[0]         = 1'b1;
    bus.REQ_ADDR[0 +: 16] = 16'h5555;
    bus.REQ_WDATA[0 +: 8] = 8'h55;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("hold_busy", 32'(busy), 32'h0);
      check("hold_we", 32'(bus.RAM_WE), 32'h0);
      check("hold_ack", 32'(bus.ACK), 32'h0);
    end
    hold = 1'b0;
    tick();
    check("unhold_grant", 32'(grant_idx), 32'h0);
    check("unhold_busy", 32'(busy), 32'h1);
    check("unhold_addr", 32'(bus.RAM_ADDR), 32'h5555);
    hold = 1'b1;
    tick();
    check("hold_in_access_ack", 32'(bus.ACK), 32'h1);
    bus.REQ_WR[0] = 1'b0;
    tick();
    bus.REQ_RR[1] = 1'b1;
    tick();
    check("hold_again_busy", 32'(busy), 32'h0);
    bus.REQ_RR[1] = 1'b0;
    hold = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
